// File: rtl/cplx_recursion_bank.sv
// Bank of first-order complex fixed-point recursions y = F*y + x.
// Optional clamping with sticky overflow: CPLX_RECURSION_SATURATION_EN.
module cplx_recursion_bank #(
  parameter  int CHANNELS  = 4,
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 16,
  parameter  int COEF_FRAC = 15,
  localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [CHANNELS*2*DATA_W-1:0] in_data,
  input  logic [CHANNELS*2*DATA_W-1:0] init_data,
  input  logic                         clear,
  input  logic                         coef_we,
  input  logic [SEL_W-1:0]             coef_sel,
  input  logic [2*COEF_W-1:0]          coef_data,
  output logic                         out_valid,
  output logic [CHANNELS*2*DATA_W-1:0] out_data,
  output logic [CHANNELS-1:0]          ovf
);

  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SW = DATA_W + 2;
  localparam logic signed [PW-1:0] RND = PW'(1) << (COEF_FRAC - 1);

  logic [CHANNELS*2*DATA_W-1:0] r_data;
  logic [2*COEF_W-1:0]          r_coef [CHANNELS];
  logic                         r_valid;
  logic [CHANNELS*2*DATA_W-1:0] w_next;
  logic [CHANNELS-1:0]          w_ovf;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam int B = k * 2 * DATA_W;

    logic signed [DATA_W-1:0] w_y_re, w_y_im;
    logic signed [DATA_W-1:0] w_x_re, w_x_im;
    logic signed [COEF_W-1:0] w_f_re, w_f_im;
    logic signed [PW-1:0]     w_m_rr, w_m_ii;
    logic signed [PW-1:0]     w_m_ri, w_m_ir;
    logic signed [PW-1:0]     w_p_re, w_p_im;
    logic signed [PW-1:0]     w_h_re, w_h_im;
    logic signed [SW-1:0]     w_s_re, w_s_im;
    logic [DATA_W-1:0]        w_n_re, w_n_im;
    logic                     w_unused;

    assign w_y_re = r_data[B+DATA_W +: DATA_W];
    assign w_y_im = r_data[B +: DATA_W];
    assign w_x_re = in_data[B+DATA_W +: DATA_W];
    assign w_x_im = in_data[B +: DATA_W];
    assign w_f_re = r_coef[k][COEF_W +: COEF_W];
    assign w_f_im = r_coef[k][0 +: COEF_W];

    assign w_m_rr = PW'(w_y_re) * PW'(w_f_re);
    assign w_m_ii = PW'(w_y_im) * PW'(w_f_im);
    assign w_m_ri = PW'(w_y_re) * PW'(w_f_im);
    assign w_m_ir = PW'(w_y_im) * PW'(w_f_re);
    assign w_p_re = w_m_rr - w_m_ii;
    assign w_p_im = w_m_ri + w_m_ir;

    assign w_h_re = (w_p_re + RND) >>> COEF_FRAC;
    assign w_h_im = (w_p_im + RND) >>> COEF_FRAC;

    assign w_s_re = w_h_re[SW-1:0] + SW'(w_x_re);
    assign w_s_im = w_h_im[SW-1:0] + SW'(w_x_im);

`ifdef CPLX_RECURSION_SATURATION_EN
    logic w_o_re, w_o_im;
    // Out of range when the bits above the DATA_W sign bit disagree.
    assign w_o_re = ~(&w_s_re[SW-1:DATA_W-1])
                  & (|w_s_re[SW-1:DATA_W-1]);
    assign w_o_im = ~(&w_s_im[SW-1:DATA_W-1])
                  & (|w_s_im[SW-1:DATA_W-1]);
    assign w_n_re = w_o_re
      ? {w_s_re[SW-1], {(DATA_W-1){~w_s_re[SW-1]}}}
      : w_s_re[DATA_W-1:0];
    assign w_n_im = w_o_im
      ? {w_s_im[SW-1], {(DATA_W-1){~w_s_im[SW-1]}}}
      : w_s_im[DATA_W-1:0];
    assign w_ovf[k] = w_o_re | w_o_im;
    assign w_unused = ^{w_h_re[PW-1:SW], w_h_im[PW-1:SW]};
`else
    assign w_n_re   = w_s_re[DATA_W-1:0];
    assign w_n_im   = w_s_im[DATA_W-1:0];
    assign w_ovf[k] = 1'b0;
    assign w_unused = ^{w_h_re[PW-1:SW], w_h_im[PW-1:SW],
                        w_s_re[SW-1:DATA_W], w_s_im[SW-1:DATA_W]};
`endif

    assign w_next[B+DATA_W +: DATA_W] = w_n_re;
    assign w_next[B +: DATA_W]        = w_n_im;
  end

`ifdef CPLX_RECURSION_SATURATION_EN
  logic [CHANNELS-1:0] r_ovf;

  // Sticky overflow: set on a saturating update, cleared by clear/reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= '0;
    end else if (clear) begin
      r_ovf <= '0;
    end else if (in_valid) begin
      r_ovf <= r_ovf | w_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = ^w_ovf;
  assign ovf = '0;
`endif

  // State, valid pulse and coefficient bank; clear beats a sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) r_coef[k] <= '0;
    end else begin
      if (clear) begin
        r_data  <= init_data;
        r_valid <= 1'b0;
      end else if (in_valid) begin
        r_data  <= w_next;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (coef_we && coef_sel == SEL_W'(k)) r_coef[k] <= coef_data;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_cplx_recursion_bank.sv
// Directed bench for cplx_recursion_bank with a per-cycle reference model.
// Covers both builds via CPLX_RECURSION_SATURATION_EN.
module tb_cplx_recursion_bank;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int CF = 15;
  localparam int VW = CH * 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic [VW-1:0] init_data = '0;
  logic          clear = 1'b0;
  logic          coef_we = 1'b0;
  logic [1:0]    coef_sel = '0;
  logic [2*CW-1:0] coef_data = '0;
  logic          out_valid;
  logic [VW-1:0] out_data;
  logic [CH-1:0] ovf;

  int n_chk = 0;
  int n_err = 0;

  int m_re [CH] = '{default: 0};
  int m_im [CH] = '{default: 0};
  int c_re [CH] = '{default: 0};
  int c_im [CH] = '{default: 0};
  bit m_ovf [CH] = '{default: 0};
  bit m_v = 0;

  cplx_recursion_bank #(
    .CHANNELS(CH), .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(CF)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .init_data(init_data), .clear(clear), .coef_we(coef_we),
    .coef_sel(coef_sel), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic void reduce(input longint s, output int r,
                                 output bit o);
    longint hi = (longint'(1) << (DW - 1)) - 1;
    longint lo = -(longint'(1) << (DW - 1));
    longint t;
`ifdef CPLX_RECURSION_SATURATION_EN
    o = 1'b0;
    t = s;
    if (s > hi) begin t = hi; o = 1'b1; end
    if (s < lo) begin t = lo; o = 1'b1; end
    r = int'(t);
`else
    o = 1'b0;
    t = s & ((longint'(1) << DW) - 1);
    if (t > hi) t = t - (longint'(1) << DW);
    r = int'(t);
`endif
  endfunction

  // Reference model: complex multiply with half-up rounding, then add.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        m_re[k] = 0; m_im[k] = 0; c_re[k] = 0; c_im[k] = 0;
        m_ovf[k] = 0;
      end
      m_v = 0;
    end else begin
      if (clear) begin
        for (int k = 0; k < CH; k++) begin
          m_re[k] = $signed(init_data[k*2*DW+DW +: DW]);
          m_im[k] = $signed(init_data[k*2*DW +: DW]);
          m_ovf[k] = 0;
        end
        m_v = 0;
      end else if (in_valid) begin
        for (int k = 0; k < CH; k++) begin
          longint pr, pi, hr, hi;
          int xr, xi, nr, ni;
          bit orr, oi;
          xr = $signed(in_data[k*2*DW+DW +: DW]);
          xi = $signed(in_data[k*2*DW +: DW]);
          pr = longint'(m_re[k]) * c_re[k] - longint'(m_im[k]) * c_im[k];
          pi = longint'(m_re[k]) * c_im[k] + longint'(m_im[k]) * c_re[k];
          hr = (pr + (longint'(1) << (CF - 1))) >>> CF;
          hi = (pi + (longint'(1) << (CF - 1))) >>> CF;
          reduce(hr + xr, nr, orr);
          reduce(hi + xi, ni, oi);
          m_re[k] = nr;
          m_im[k] = ni;
          m_ovf[k] = m_ovf[k] | orr | oi;
        end
        m_v = 1;
      end else begin
        m_v = 0;
      end
      if (coef_we && coef_sel < CH) begin
        c_re[coef_sel] = $signed(coef_data[CW +: CW]);
        c_im[coef_sel] = $signed(coef_data[0 +: CW]);
      end
    end
  end

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic [VW-1:0] e_d;
    logic [VW-1:0] e_o;
    e_d = '0;
    e_o = '0;
    for (int k = 0; k < CH; k++) begin
      e_d[k*2*DW+DW +: DW] = DW'(m_re[k]);
      e_d[k*2*DW +: DW]    = DW'(m_im[k]);
      e_o[k] = m_ovf[k];
    end
    chk("model_data", out_data, e_d);
    chk("model_valid", VW'(out_valid), VW'(m_v));
    chk("model_ovf", VW'(ovf), e_o);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int k, input int re, input int im);
    in_data[k*2*DW+DW +: DW] = DW'(re);
    in_data[k*2*DW +: DW]    = DW'(im);
  endtask

  task automatic set_init(input int k, input int re, input int im);
    init_data[k*2*DW+DW +: DW] = DW'(re);
    init_data[k*2*DW +: DW]    = DW'(im);
  endtask

  task automatic wcoef(input int k, input int re, input int im);
    coef_we   = 1'b1;
    coef_sel  = 2'(k);
    coef_data = {CW'(re), CW'(im)};
  endtask

  // Literal expectation, applied to both the DUT and the model.
  task automatic exp_ch(input string nm, input int k,
                        input int re, input int im);
    int ar, ai;
    ar = $signed(out_data[k*2*DW+DW +: DW]);
    ai = $signed(out_data[k*2*DW +: DW]);
    chk({nm, "_re"}, VW'(ar), VW'(re));
    chk({nm, "_im"}, VW'(ai), VW'(im));
    chk({nm, "_mre"}, VW'(m_re[k]), VW'(re));
    chk({nm, "_mim"}, VW'(m_im[k]), VW'(im));
  endtask

  int exp1 [5] = '{1000, 1500, 1750, 1875, 1938};
  int ovf_exp;
  int ovf_bit;

  initial begin
`ifdef CPLX_RECURSION_SATURATION_EN
    ovf_exp = 32767;
    ovf_bit = 1;
`else
    ovf_exp = -25537;
    ovf_bit = 0;
`endif
    #2 rst = 1'b0;
    cyc();
    cyc();
    chk("rst_data", out_data, '0);
    chk("rst_valid", VW'(out_valid), '0);
    chk("rst_ovf", VW'(ovf), '0);
    rst = 1'b1;

    wcoef(0, 16384, 0);
    cyc();
    coef_we = 1'b0;
    set_x(0, 1000, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp_ch("basic", 0, exp1[i], 0);
      chk("basic_valid", VW'(out_valid), VW'(1));
    end
    in_valid = 1'b0;
    in_data = '0;
    cyc();
    chk("idle_valid", VW'(out_valid), '0);

    set_init(1, 1000, 0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    init_data = '0;
    exp_ch("init1", 1, 1000, 0);
    wcoef(1, 0, 16384);
    cyc();
    coef_we = 1'b0;
    in_valid = 1'b1;
    cyc();
    exp_ch("cmul1", 1, 0, 500);
    cyc();
    exp_ch("cmul2", 1, -250, 0);
    in_valid = 1'b0;

    wcoef(2, 16384, 0);
    set_x(2, 100, 0);
    in_valid = 1'b1;
    cyc();
    coef_we = 1'b0;
    exp_ch("coef_old", 2, 100, 0);
    cyc();
    exp_ch("coef_new", 2, 150, 0);
    in_valid = 1'b0;
    in_data = '0;
    cyc();

    wcoef(3, 32767, 0);
    cyc();
    coef_we = 1'b0;
    set_x(3, 20000, 0);
    in_valid = 1'b1;
    cyc();
    exp_ch("ovf1", 3, 20000, 0);
    cyc();
    exp_ch("ovf2", 3, ovf_exp, 0);
    chk("ovf_flag", VW'(ovf[3]), VW'(ovf_bit));
    in_valid = 1'b0;
    in_data = '0;
    cyc();

    set_init(0, 7, -7);
    set_x(0, 5, 5);
    clear = 1'b1;
    in_valid = 1'b1;
    cyc();
    clear = 1'b0;
    in_valid = 1'b0;
    exp_ch("clr", 0, 7, -7);
    chk("clr_valid", VW'(out_valid), '0);
    chk("clr_ovf", VW'(ovf), '0);

    for (int i = 0; i < 10; i++) begin
      cyc();
      exp_ch("hold", 0, 7, -7);
      chk("hold_valid", VW'(out_valid), '0);
    end

    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_data", out_data, '0);
    chk("arst_valid", VW'(out_valid), '0);
    chk("arst_ovf", VW'(ovf), '0);
    @(posedge clk);
    #1 rst = 1'b1;
    in_data = '0;
    set_x(0, 3, 4);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    exp_ch("post_rst", 0, 3, 4);
    chk("post_valid", VW'(out_valid), VW'(1));
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
